decode_stage: RTL and testbench

Registered, parametrised RV32 instruction-decode stage sitting between fetch and execute. It decodes one instruction per cycle into `control_ex_s` plus a sign-extended immediate and adds optional M-extension and SYSTEM/FENCE decoding. It detects illegal encodings and provides a two-entry skid buffer with valid/ready handshakes on both sides, plus a pipeline flush.

---
 rtl/rapid_pkg.sv | 46 ++++
 rtl/decode_core.sv | 133 +++++++++++++
 rtl/decode_stage.sv | 90 +++++++++
 tb/tb_decode_stage.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/rapid_pkg.sv
// rapid_pkg: shared RV32 decode types and opcode constants.
// Provides control_ex_s (controls handed to execute), its all-zero default,
// the datapath width XLEN and the 7-bit major opcodes of each family.
package rapid_pkg;

    localparam int XLEN = 32;

    // AUIPC; LUI is the same pattern with bit 5 set.
    localparam logic [6:0] upper_family       = 7'b0010111;
    localparam logic [6:0] uncond_branch_jal  = 7'b1101111;
    localparam logic [6:0] uncond_branch_jalr = 7'b1100111;
    localparam logic [6:0] cond_branch_family = 7'b1100011;
    localparam logic [6:0] mem_load_family    = 7'b0000011;
    localparam logic [6:0] mem_store_family   = 7'b0100011;
    localparam logic [6:0] imm_family         = 7'b0010011;
    localparam logic [6:0] reg_family         = 7'b0110011;
    localparam logic [6:0] system_family      = 7'b1110011;
    localparam logic [6:0] fence_family       = 7'b0001111;

    typedef struct packed {
        logic [31:0] debug_instruction;
        logic        upper;
        logic        uncond_branch;
        logic        cond_branch;
        logic        mem_load;
        logic        mem_store;
        logic        alu_imm;
        logic        alu_reg;
        logic        iop;
        logic [2:0]  fcs_opcode;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rs1_out;
        logic        rs2_out;
        logic        rd_we;
        logic        mul_div;
        logic        system;
        logic        illegal;
    } control_ex_s;

    function automatic control_ex_s control_ex_s_default();
        return '0;
    endfunction

endpackage

// File: rtl/decode_core.sv
// decode_core: combinational RV32 instruction decoder.
// Ports: ins_i (instruction word) -> ctrl_o (execute controls),
//        imm_o (immediate sign-extended to XLEN).
// debug_instruction always carries the raw word, so execute can report the
// offending encoding when it traps on an illegal instruction.
module decode_core #(
    parameter int XLEN          = rapid_pkg::XLEN,
    parameter bit ENABLE_M      = 1'b0,
    parameter bit ENABLE_SYSTEM = 1'b1
) (
    input  logic [31:0]              ins_i,
    output rapid_pkg::control_ex_s   ctrl_o,
    output logic signed [XLEN-1:0]   imm_o
);
    import rapid_pkg::*;

    logic [6:0] op, f7;
    logic [2:0] f3;
    logic signed [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic wr, r1, r2, bad;

    assign op    = ins_i[6:0];
    assign f3    = ins_i[14:12];
    assign f7    = ins_i[31:25];
    assign imm_i = XLEN'(signed'(ins_i[31:20]));
    assign imm_s = XLEN'(signed'({ins_i[31:25], ins_i[11:7]}));
    assign imm_b = XLEN'(signed'({ins_i[31], ins_i[7], ins_i[30:25], ins_i[11:8], 1'b0}));
    assign imm_u = XLEN'(signed'({ins_i[31:12], 12'b0}));
    assign imm_j = XLEN'(signed'({ins_i[31], ins_i[19:12], ins_i[20], ins_i[30:21], 1'b0}));

    always_comb begin
        ctrl_o = control_ex_s_default();
        ctrl_o.debug_instruction = ins_i;
        ctrl_o.fcs_opcode = f3;
        imm_o = '0;
        wr = 1'b0;
        r1 = 1'b0;
        r2 = 1'b0;
        bad = 1'b0;
        case (op)
            upper_family, upper_family ^ 7'b0100000: begin
                ctrl_o.upper = 1'b1;
                ctrl_o.iop = ~op[5];
                wr = 1'b1;
                imm_o = imm_u;
            end
            uncond_branch_jal: begin
                ctrl_o.uncond_branch = 1'b1;
                wr = 1'b1;
                imm_o = imm_j;
            end
            uncond_branch_jalr: begin
                ctrl_o.uncond_branch = 1'b1;
                ctrl_o.iop = 1'b1;
                wr = 1'b1;
                r1 = 1'b1;
                imm_o = imm_i;
                bad = f3 != 3'b000;
            end
            cond_branch_family: begin
                ctrl_o.cond_branch = 1'b1;
                r1 = 1'b1;
                r2 = 1'b1;
                imm_o = imm_b;
                bad = f3[2:1] == 2'b01;
            end
            mem_load_family: begin
                ctrl_o.mem_load = 1'b1;
                wr = 1'b1;
                r1 = 1'b1;
                imm_o = imm_i;
                bad = f3 == 3'b011 || f3[2:1] == 2'b11;
            end
            mem_store_family: begin
                ctrl_o.mem_store = 1'b1;
                ctrl_o.iop = 1'b1;
                r1 = 1'b1;
                r2 = 1'b1;
                imm_o = imm_s;
                bad = f3 > 3'b010;
            end
            imm_family: begin
                ctrl_o.alu_imm = 1'b1;
                ctrl_o.iop = f3 == 3'b101 && ins_i[30];
                wr = 1'b1;
                r1 = 1'b1;
                imm_o = imm_i;
                // Shift amounts live in imm[4:0]; the upper bits must be a valid funct7.
                bad = (f3 == 3'b001 && f7 != 7'b0000000) ||
                      (f3 == 3'b101 && f7 != 7'b0000000 && f7 != 7'b0100000);
            end
            reg_family: begin
                ctrl_o.alu_reg = 1'b1;
                ctrl_o.iop = ins_i[30];
                wr = 1'b1;
                r1 = 1'b1;
                r2 = 1'b1;
                if (f7 == 7'b0000001) begin
                    ctrl_o.mul_div = 1'b1;
                    ctrl_o.iop = 1'b0;
                    bad = !ENABLE_M;
                end else begin
                    bad = !(f7 == 7'b0000000 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)));
                end
            end
            system_family: begin
                // Only ECALL (all zero) and EBREAK (bit 20 set) are decoded.
                ctrl_o.system = 1'b1;
                ctrl_o.fcs_opcode = 3'b000;
                imm_o = imm_i;
                bad = !ENABLE_SYSTEM || (|ins_i[31:21]) || (|ins_i[19:7]);
            end
            fence_family: begin
                ctrl_o.fcs_opcode = 3'b000;
                bad = !ENABLE_SYSTEM;
            end
            default: bad = 1'b1;
        endcase
        ctrl_o.rs1 = r1 ? ins_i[19:15] : 5'd0;
        ctrl_o.rs2 = r2 ? ins_i[24:20] : 5'd0;
        ctrl_o.rd = wr ? ins_i[11:7] : 5'd0;
        ctrl_o.rs1_out = r1;
        ctrl_o.rs2_out = r2;
        ctrl_o.rd_we = wr && ins_i[11:7] != 5'd0;
        if (bad) begin
            ctrl_o = control_ex_s_default();
            ctrl_o.debug_instruction = ins_i;
            ctrl_o.illegal = 1'b1;
            imm_o = '0;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered RV32 decode stage with a two-entry skid buffer.
// Ports: i_clk/i_rst (async active-high), fetch side i_valid/o_ready with
//        i_instruction/i_pc, execute side o_valid/i_ready with
//        o_control_signal/o_imm/o_pc, and i_flush to drop everything in flight.
// The output register is the head of the queue, the skid register the tail;
// o_ready is simply "skid empty", so it drops the cycle after the skid fills.
module decode_stage #(
    parameter int XLEN          = rapid_pkg::XLEN,
    parameter bit ENABLE_M      = 1'b0,
    parameter bit ENABLE_SYSTEM = 1'b1
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [31:0]            i_instruction,
    input  logic [XLEN-1:0]        i_pc,
    input  logic                   i_flush,
    output logic                   o_valid,
    input  logic                   i_ready,
    output rapid_pkg::control_ex_s o_control_signal,
    output logic signed [XLEN-1:0] o_imm,
    output logic [XLEN-1:0]        o_pc
);
    import rapid_pkg::*;

    typedef struct packed {
        control_ex_s            ctrl;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
    } entry_t;

    entry_t dec, out_q, out_d, skid_q, skid_d;
    control_ex_s dec_ctrl;
    logic signed [XLEN-1:0] dec_imm;
    logic out_valid_q, out_valid_d, skid_valid_q, skid_valid_d, accept;

    decode_core #(
        .XLEN(XLEN),
        .ENABLE_M(ENABLE_M),
        .ENABLE_SYSTEM(ENABLE_SYSTEM)
    ) u_core (
        .ins_i(i_instruction),
        .ctrl_o(dec_ctrl),
        .imm_o(dec_imm)
    );

    assign dec = '{dec_ctrl, dec_imm, i_pc};
    assign accept = i_valid && o_ready;
    assign o_ready = !skid_valid_q;
    assign o_valid = out_valid_q;
    assign o_control_signal = out_q.ctrl;
    assign o_imm = out_q.imm;
    assign o_pc = out_q.pc;

    always_comb begin
        out_valid_d = out_valid_q;
        skid_valid_d = skid_valid_q;
        out_d = out_q;
        skid_d = skid_q;
        if (i_flush) begin
            out_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || i_ready) begin
            // Head is free: the oldest held entry moves up before a new one.
            out_valid_d = skid_valid_q || accept;
            out_d = skid_valid_q ? skid_q : (accept ? dec : out_q);
            skid_valid_d = skid_valid_q && accept;
            skid_d = (skid_valid_q && accept) ? dec : skid_q;
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_d = dec;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            out_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            out_q <= '{control_ex_s_default(), '0, '0};
            skid_q <= '{control_ex_s_default(), '0, '0};
        end else begin
            out_valid_q <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            out_q <= out_d;
            skid_q <= skid_d;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed and random checks of decode_stage against a queue model.
module tb_decode_stage;
    import rapid_pkg::*;

    logic clk = 1'b0;
    logic rst, i_valid, i_flush, i_ready;
    logic [31:0] ins, pc;
    logic o_ready, o_valid, nm_ready, nm_valid;
    control_ex_s o_ctrl, nm_ctrl;
    logic signed [31:0] o_imm, nm_imm;
    logic [31:0] o_pc, nm_pc;
    int n_assert = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] pc;
    } ent_t;
    ent_t q[$];

    // LUI AUIPC JAL JALR BRANCH LOAD STORE OP-IMM OP SYSTEM FENCE
    logic [6:0] opc [11] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73, 7'h0f};

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32), .ENABLE_M(1'b1), .ENABLE_SYSTEM(1'b1)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_instruction(ins), .i_pc(pc), .i_flush(i_flush), .o_valid(o_valid),
        .i_ready(i_ready), .o_control_signal(o_ctrl), .o_imm(o_imm), .o_pc(o_pc)
    );

    decode_stage #(.XLEN(32), .ENABLE_M(1'b0), .ENABLE_SYSTEM(1'b0)) dut_nm (
        .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(nm_ready),
        .i_instruction(ins), .i_pc(pc), .i_flush(i_flush), .o_valid(nm_valid),
        .i_ready(i_ready), .o_control_signal(nm_ctrl), .o_imm(nm_imm), .o_pc(nm_pc)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Table-driven reference decode: family lookup, legality rules, then field tables.
    function automatic void ref_decode(input logic [31:0] w, input bit en_m, input bit en_sys,
                                       output control_ex_s c, output logic [31:0] imm);
        logic [10:0] reads1 = 11'h1F8;
        logic [10:0] reads2 = 11'h150;
        logic [10:0] writes = 11'h1AF;
        int fam, f3, f7;
        bit ok;
        fam = -1;
        f3 = int'(w[14:12]);
        f7 = int'(w[31:25]);
        for (int k = 0; k < 11; k++) if (w[6:0] == opc[k]) fam = k;
        case (fam)
            -1: ok = 0;
            3: ok = f3 == 0;
            4: ok = f3 != 2 && f3 != 3;
            5: ok = f3 != 3 && f3 < 6;
            6: ok = f3 <= 2;
            7: ok = f3 == 1 ? f7 == 0 : (f3 == 5 ? (f7 == 0 || f7 == 32) : 1'b1);
            8: ok = f7 == 0 || (f7 == 32 && (f3 == 0 || f3 == 5)) || (f7 == 1 && en_m);
            9: ok = en_sys && (w[31:7] == 25'h0 || w[31:7] == 25'h2000);
            10: ok = en_sys;
            default: ok = 1;
        endcase
        c = '0;
        imm = 0;
        c.debug_instruction = w;
        if (!ok) begin
            c.illegal = 1'b1;
            return;
        end
        c.upper = fam < 2;
        c.uncond_branch = fam == 2 || fam == 3;
        c.cond_branch = fam == 4;
        c.mem_load = fam == 5;
        c.mem_store = fam == 6;
        c.alu_imm = fam == 7;
        c.alu_reg = fam == 8;
        c.system = fam == 9;
        c.mul_div = fam == 8 && f7 == 1;
        c.iop = fam == 1 || fam == 3 || fam == 6 || (fam == 7 && f3 == 5 && f7 == 32) || (fam == 8 && f7 == 32);
        c.fcs_opcode = fam >= 9 ? 3'd0 : w[14:12];
        c.rs1_out = reads1[fam];
        c.rs2_out = reads2[fam];
        c.rs1 = c.rs1_out ? w[19:15] : 5'd0;
        c.rs2 = c.rs2_out ? w[24:20] : 5'd0;
        c.rd = writes[fam] ? w[11:7] : 5'd0;
        c.rd_we = c.rd != 5'd0;
        case (fam)
            0, 1: imm = {w[31:12], 12'b0};
            2: imm = 32'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
            3, 5, 7, 9: imm = 32'($signed(w[31:20]));
            4: imm = 32'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
            6: imm = 32'($signed({w[31:25], w[11:7]}));
            default: imm = 0;
        endcase
    endfunction

    function automatic logic [31:0] rand_ins();
        logic [6:0] f7s [3] = '{7'h00, 7'h20, 7'h01};
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(0, 9) == 0) return w;
        w[6:0] = opc[$urandom_range(0, 10)];
        if ($urandom_range(0, 1) == 1) w[31:25] = f7s[$urandom_range(0, 2)];
        if (w[6:0] == 7'h73 && $urandom_range(0, 1) == 1) w = $urandom_range(0, 1) == 1 ? 32'h00100073 : 32'h00000073;
        return w;
    endfunction

    task automatic check_model();
        control_ex_s ec;
        logic [31:0] ei;
        chk("o_valid", o_valid, q.size() != 0);
        chk("o_ready", o_ready, q.size() < 2);
        chk("nm_valid", nm_valid, q.size() != 0);
        if (q.size() != 0) begin
            ref_decode(q[0].ins, 1'b1, 1'b1, ec, ei);
            chk("ctrl", o_ctrl, ec);
            chk("imm", $unsigned(o_imm), ei);
            chk("pc", o_pc, q[0].pc);
            ref_decode(q[0].ins, 1'b0, 1'b0, ec, ei);
            chk("nm_ctrl", nm_ctrl, ec);
            chk("nm_imm", $unsigned(nm_imm), ei);
        end
    endtask

    // Called at a falling edge: drive one cycle of inputs, advance the model, check after the edge.
    task automatic step(input bit v, input logic [31:0] w, input logic [31:0] p, input bit rdy, input bit fl);
        bit acc;
        i_valid = v;
        ins = w;
        pc = p;
        i_ready = rdy;
        i_flush = fl;
        if (fl) begin
            q.delete();
        end else begin
            acc = v && q.size() < 2;
            if (q.size() != 0 && rdy) void'(q.pop_front());
            if (acc) q.push_back('{w, p});
        end
        @(negedge clk);
        check_model();
    endtask

    initial begin
        rst = 1'b1;
        i_valid = 1'b1;
        ins = 32'h00500093;
        pc = 32'h40;
        i_ready = 1'b0;
        i_flush = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", o_valid, 1'b0);
        chk("rst_ready", o_ready, 1'b1);
        chk("rst_ctrl", o_ctrl, control_ex_s_default());
        chk("rst_imm", $unsigned(o_imm), 0);
        chk("rst_pc", o_pc, 0);
        rst = 1'b0;

        step(1, 32'h00500093, 32'h100, 1, 0);
        chk("addi_alu_imm", o_ctrl.alu_imm, 1);
        chk("addi_rd", o_ctrl.rd, 1);
        chk("addi_rs1", o_ctrl.rs1, 0);
        chk("addi_rs1_out", o_ctrl.rs1_out, 1);
        chk("addi_rd_we", o_ctrl.rd_we, 1);
        chk("addi_imm", $unsigned(o_imm), 5);
        chk("addi_valid", o_valid, 1);

        step(1, 32'hFFDFF0EF, 32'h200, 1, 0);
        chk("jal_uncond", o_ctrl.uncond_branch, 1);
        chk("jal_iop", o_ctrl.iop, 0);
        chk("jal_imm", $unsigned(o_imm), 32'hFFFFFFFC);
        chk("jal_pc", o_pc, 32'h200);

        step(1, 32'h022081B3, 32'h300, 1, 0);
        chk("mul_mul_div", o_ctrl.mul_div, 1);
        chk("mul_rs1", o_ctrl.rs1, 1);
        chk("mul_rs2", o_ctrl.rs2, 2);
        chk("mul_rd", o_ctrl.rd, 3);
        chk("mul_nom_illegal", nm_ctrl.illegal, 1);
        step(1, 32'h00000000, 32'h304, 1, 0);
        chk("zero_illegal", o_ctrl.illegal, 1);

        step(0, 32'h0, 32'h0, 1, 0);
        chk("drain_valid", o_valid, 0);
        step(1, 32'h00100113, 32'h400, 0, 0);
        step(1, 32'h00200193, 32'h404, 0, 0);
        chk("bp_ready", o_ready, 0);
        chk("bp_pc_a", o_pc, 32'h400);
        step(1, 32'h00300213, 32'h408, 0, 0);
        chk("bp_hold_pc", o_pc, 32'h400);
        chk("bp_hold_imm", $unsigned(o_imm), 1);
        step(0, 32'h0, 32'h0, 1, 0);
        chk("bp_pc_b", o_pc, 32'h404);
        step(0, 32'h0, 32'h0, 1, 0);
        chk("bp_empty", o_valid, 0);

        step(1, 32'h00500093, 32'h500, 0, 0);
        step(1, 32'h00600093, 32'h504, 0, 0);
        step(1, 32'h00700093, 32'h508, 0, 1);
        chk("flush_valid", o_valid, 0);
        chk("flush_ready", o_ready, 1);
        step(0, 32'h0, 32'h0, 1, 0);
        step(0, 32'h0, 32'h0, 1, 0);
        chk("flush_gone", o_valid, 0);

        step(1, 32'h00500093, 32'h600, 0, 0);
        step(1, 32'h00600093, 32'h604, 0, 0);
        i_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", o_valid, 0);
        chk("arst_ready", o_ready, 1);
        chk("arst_pc", o_pc, 0);
        chk("arst_imm", $unsigned(o_imm), 0);
        chk("arst_ctrl", o_ctrl, control_ex_s_default());
        #1 rst = 1'b0;
        q.delete();
        @(negedge clk);
        check_model();
        step(1, 32'h00500093, 32'h700, 1, 0);
        chk("arst_first_valid", o_valid, 1);
        chk("arst_first_pc", o_pc, 32'h700);

        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 3) != 0, rand_ins(), $urandom, $urandom_range(0, 2) != 0, $urandom_range(0, 29) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
